// File: rtl/lsu.sv
// lsu: memory-stage load/store unit driving a req/ack data bus with load alignment and store strobes.
// Optional macro LSU_MISALIGN_EXC_EN: flag and suppress misaligned accesses instead of force-aligning them.
module lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          stall_i,
  input  logic                rd_we_i,
  input  logic [DATA_W-1:0]   rd_mem_data_i,
  input  logic [4:0]          rd_addr_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic                mem_re_i,
  input  logic                mem_we_i,
  input  logic [1:0]          mem_size_i,
  input  logic                mem_uns_i,
  output logic                mem_req_o,
  output logic                mem_wr_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                rd_we_o,
  output logic [DATA_W-1:0]   rd_wdata_o,
  output logic [4:0]          rd_addr_o,
`ifdef LSU_MISALIGN_EXC_EN
  output logic                misalign_o,
`endif
  output logic                stall_req_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_q;
  logic              is_access, is_store, is_load, acc, suppress;
  logic              ack_now, load_done, req, stall_req;
  logic [DATA_W-1:0] src;
  logic              unused_stall;

  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] w,
                                                 input logic [1:0] lane,
                                                 input logic [1:0] size,
                                                 input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   fmt_load = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   fmt_load = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] fmt_wdata(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] size);
    case (size)
      2'b00:   fmt_wdata = {4{d[7:0]}};
      2'b01:   fmt_wdata = {2{d[15:0]}};
      default: fmt_wdata = d;
    endcase
  endfunction

  function automatic logic [DATA_W/8-1:0] fmt_strb(input logic [1:0] lane,
                                                   input logic [1:0] size);
    case (size)
      2'b00:   fmt_strb = 4'b0001 << lane;
      2'b01:   fmt_strb = lane[1] ? 4'b1100 : 4'b0011;
      default: fmt_strb = 4'hF;
    endcase
  endfunction

  // A simultaneous read+write request is a store.
  assign is_access = mem_re_i | mem_we_i;
  assign is_store  = mem_we_i;
  assign is_load   = mem_re_i & ~mem_we_i;

`ifdef LSU_MISALIGN_EXC_EN
  logic aligned;
  always_comb begin
    aligned = 1'b1;
    case (mem_size_i)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~mem_addr_i[0];
      default: aligned = (mem_addr_i[1:0] == 2'b00);
    endcase
  end
  assign acc        = is_access & aligned;
  assign suppress   = is_access & ~aligned;
  assign misalign_o = rst_n & suppress;
`else
  // Misaligned accesses proceed: the lane logic only looks at the bits that survive forced alignment.
  assign acc      = is_access;
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       data_q <= '0;
    else if (ack_now) data_q <= mem_rdata_i;
  end

  // DONE parks a completed access so a held EX/LS register does not re-issue it.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    stall_req = 1'b0;
    case (state)
      S_IDLE: begin
        req = acc;
        if (acc) begin
          if (mem_ack_i) begin
            state_nxt = stall_i[4] ? S_DONE : S_IDLE;
          end else begin
            state_nxt = S_WAIT;
            stall_req = 1'b1;
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (mem_ack_i) state_nxt = stall_i[4] ? S_DONE : S_IDLE;
        else           stall_req = 1'b1;
      end
      S_DONE: begin
        if (!stall_i[4]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ack_now   = mem_ack_i & req;
  assign load_done = ack_now | (state == S_DONE);
  assign src       = ack_now ? mem_rdata_i : data_q;

  assign mem_req_o   = rst_n & req;
  assign stall_req_o = rst_n & stall_req;
  assign mem_wr_o    = mem_req_o & is_store;
  assign mem_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
  assign mem_wdata_o = fmt_wdata(rd_mem_data_i, mem_size_i);
  assign mem_wstrb_o = (rst_n & is_store & acc) ? fmt_strb(mem_addr_i[1:0], mem_size_i) : '0;

  assign rd_addr_o  = rd_addr_i;
  assign rd_we_o    = rst_n & rd_we_i & ~suppress & ~(is_load & ~load_done);
  assign rd_wdata_o = !rst_n ? '0 :
                      is_load ? fmt_load(src, mem_addr_i[1:0], mem_size_i, mem_uns_i) :
                      rd_mem_data_i;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit (memory stage). Consumes the EX/LS pipeline register outputs and drives a req/ack data-memory bus.
- Aligns and sign/zero-extends load data, and generates byte strobes for stores.
- Raises a stall request to ctrl while a memory access is outstanding.
- Produces the register write-back triple for the LS/WB register.

Parameters:
- ADDR_W, 32, data-memory byte address width.
- DATA_W, 32, data width (fixed at 32; other values unsupported).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- stall_i  in  6  ctrl stall vector; bit 4 = LS stage held
- rd_we_i  in  1  register write enable from EX/LS
- rd_mem_data_i  in  32  ALU result (non-memory op) or store data
- rd_addr_i  in  5  destination register
- mem_addr_i  in  ADDR_W  effective byte address
- mem_re_i  in  1  load
- mem_we_i  in  1  store
- mem_size_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_uns_i  in  1  zero-extend load
- mem_req_o  out  1  bus request
- mem_wr_o  out  1  bus write
- mem_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata_o  out  32  store data replicated to lanes
- mem_wstrb_o  out  4  byte strobes
- mem_ack_i  in  1  bus completion; rdata valid same cycle
- mem_rdata_i  in  32  read data
- rd_we_o  out  1  to LS/WB
- rd_wdata_o  out  32  to LS/WB
- rd_addr_o  out  5  to LS/WB
- stall_req_o  out  1  to ctrl

Reset: clk, rst_n; one clock, asynchronous active-low reset.

Behaviour:
- Reset (rst_n low): state=IDLE, data_q=0, busy=0. Outputs while rst_n low: mem_req_o=0, stall_req_o=0, rd_we_o=0, rd_wdata_o=0, mem_wstrb_o=0.
- acc = (mem_re_i | mem_we_i) & aligned.
- aligned:
  - byte: always.
  - half: addr[0]==0.
  - word: addr[1:0]==0.
- States:
  - IDLE: mem_req_o = acc.
    - acc & mem_ack_i → access completes this cycle (zero wait). Go to DONE if stall_i[4], else stay IDLE.
    - acc & !mem_ack_i → go to WAIT.
  - WAIT: mem_req_o=1; address and wdata held stable because EX/LS is frozen.
    - On mem_ack_i: data_q ← mem_rdata_i. Go to DONE if stall_i[4], else IDLE.
  - DONE: mem_req_o=0; result comes from data_q. Go to IDLE when !stall_i[4]. Prevents re-issuing a held access while downstream is stalled.
- stall_req_o = (IDLE & acc & !mem_ack_i) | (WAIT & !mem_ack_i). Deasserts combinationally in the ack cycle.
- Store formatting:
  - byte: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - half: wdata={2{d[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - word: wstrb=4'hF.
  - Loads: wstrb=0, mem_wr_o=0.
- Load formatting:
  - Source word src = mem_rdata_i in the ack cycle, else data_q.
  - Select the lane by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend unless mem_uns_i.
- Write-back:
  - rd_addr_o = rd_addr_i.
  - rd_wdata_o = formatted load for loads, else rd_mem_data_i.
  - rd_we_o = rd_we_i & !(load not yet complete); it is 0 during IDLE/WAIT cycles without ack.
- Simultaneous: mem_re_i & mem_we_i both high → treated as store.
- Reset mid-access: WAIT abandoned; mem_req_o drops asynchronously. The bus side must tolerate a withdrawn request.

Optional Feature:
- Macro: LSU_MISALIGN_EXC_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0): asserted combinationally when (mem_re_i|mem_we_i) & !aligned.
  - The access is suppressed: no req, no stall, rd_we_o=0.
- Undefined:
  - No misalign_o port.
  - Misaligned accesses are forced aligned by clearing low address bits (half: addr[0]=0; word: addr[1:0]=0), then performed normally.

Test Plan:
- Word load addr 0x100, ack after 2 cycles with rdata 0xDEADBEEF → stall_req_o high 2 cycles, then rd_wdata_o=0xDEADBEEF, rd_we_o=1 in ack cycle; exactly one mem_req_o burst.
- Signed byte load addr 0x103, zero-wait ack, rdata 0x80112233 → rd_wdata_o=0xFFFFFF80; same with mem_uns_i=1 → 0x00000080; stall_req_o never high.
- Half store addr 0x202 data 0x0000ABCD → mem_wdata_o=0xABCDABCD, mem_wstrb_o=4'b1100, mem_wr_o=1, mem_addr_o=0x200.
- Load acked while stall_i[4]=1 held 3 extra cycles → FSM in DONE, mem_req_o=0, rd_wdata_o stable from data_q; returns to IDLE when stall_i[4] falls.
- rst_n pulsed low during WAIT → mem_req_o and stall_req_o drop immediately; state IDLE after release.
- Word load addr 0x101:
  - With LSU_MISALIGN_EXC_EN: misalign_o=1, mem_req_o=0, rd_we_o=0.
  - Without: access issued to 0x100.
